// File: rtl/store_narrow.sv
// Narrow store unit: aligns byte/halfword/word stores onto 32-bit memory lanes.
// Optional: define STORE_MISALIGN_TRAP_EN to reject misaligned halfword/word stores.
module store_narrow (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]  lane_be;
    logic [31:0] lane_data;
    logic        reject;

    logic        req_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] wdata_nxt;
    logic [3:0]  be_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic        err_nxt;
    logic        take;

    // Lane placement from the live request inputs; only used on IDLE+start.
    always_comb begin
        lane_be   = 4'b0000;
        lane_data = 32'd0;
        reject    = 1'b0;
        unique case (size)
            2'b00: begin
                lane_be   = 4'b0001 << addr[1:0];
                lane_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_be   = 4'b0011 << {addr[1], 1'b0};
                lane_data = {2{wdata[15:0]}};
`ifdef STORE_MISALIGN_TRAP_EN
                reject    = addr[0];
`endif
            end
            2'b10: begin
                lane_be   = 4'b1111;
                lane_data = wdata;
`ifdef STORE_MISALIGN_TRAP_EN
                reject    = (addr[1:0] != 2'b00);
`endif
            end
            default: begin
                reject = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = reject ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the transition.
    always_comb begin
        take      = (state == IDLE) && start;
        req_nxt   = (state_nxt == REQ);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
        err_nxt   = take && reject;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        be_nxt    = 4'b0000;
        if (take) begin
            addr_nxt  = {addr[31:2], 2'b00};
            wdata_nxt = lane_data;
        end
        if (state_nxt == REQ) begin
            be_nxt = take ? lane_be : mem_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_req   <= req_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_be    <= be_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
// Self-checking bench for store_narrow against a lane-arithmetic model.
// Directed scenarios plus randomized transactions with random ack delay.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    store_narrow dut (
        .clk(clk), .rst(rst), .start(start), .size(size),
        .addr(addr), .wdata(wdata), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected lane layout from plain arithmetic on the store rules.
    task automatic model(input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, output logic rej,
                         output logic [3:0] be, output logic [31:0] data);
        int sh;
        rej = 1'b0;
        be = 4'd0;
        data = 32'd0;
        if (s == 2'd0) begin
            sh = int'(a % 4);
            be = 4'(1 << sh);
            data = (d & 32'hFF) * 32'h01010101;
        end else if (s == 2'd1) begin
            sh = int'(a % 4) / 2 * 2;
            be = 4'(3 << sh);
            data = (d & 32'hFFFF) * 32'h00010001;
`ifdef STORE_MISALIGN_TRAP_EN
            rej = (a % 2) != 0;
`endif
        end else if (s == 2'd2) begin
            be = 4'hF;
            data = d;
`ifdef STORE_MISALIGN_TRAP_EN
            rej = (a % 4) != 0;
`endif
        end else begin
            rej = 1'b1;
        end
    endtask

    task automatic run_txn(input logic [1:0] s, input logic [31:0] a,
                           input logic [31:0] d, input int delay,
                           input bit spam, input string tag);
        logic rej;
        logic [3:0] ebe;
        logic [31:0] edata;
        logic [31:0] eaddr;
        model(s, a, d, rej, ebe, edata);
        eaddr = a - (a % 4);
        start = 1'b1;
        size = s;
        addr = a;
        wdata = d;
        cyc();
        start = 1'b0;
        size = 2'($urandom);
        addr = $urandom;
        wdata = $urandom;
        if (rej) begin
            checks++;
            if (!(done === 1'b1 && err === 1'b1 && mem_req === 1'b0
                  && mem_be === 4'd0 && busy === 1'b1)) begin
                errors++;
                $display("FAIL %s reject: done=%b err=%b req=%b be=%b busy=%b, want 1 1 0 0000 1",
                         tag, done, err, mem_req, mem_be, busy);
            end
            cyc();
            checks++;
            if (!(done === 1'b0 && busy === 1'b0 && mem_req === 1'b0)) begin
                errors++;
                $display("FAIL %s reject_idle: done=%b busy=%b req=%b, want 0 0 0",
                         tag, done, busy, mem_req);
            end
            return;
        end
        for (int i = 0; i <= delay; i++) begin
            checks++;
            if (!(mem_req === 1'b1 && busy === 1'b1 && done === 1'b0
                  && mem_be === ebe && mem_addr === eaddr
                  && mem_wdata === edata)) begin
                errors++;
                $display("FAIL %s req[%0d]: req=%b busy=%b done=%b be=%b addr=%h data=%h, want 1 1 0 %b %h %h",
                         tag, i, mem_req, busy, done, mem_be, mem_addr,
                         mem_wdata, ebe, eaddr, edata);
            end
            start = spam;
            size = 2'($urandom);
            addr = $urandom;
            wdata = $urandom;
            mem_ack = (i == delay);
            cyc();
        end
        mem_ack = 1'b0;
        checks++;
        if (!(done === 1'b1 && err === 1'b0 && mem_req === 1'b0
              && mem_be === 4'd0 && busy === 1'b1)) begin
            errors++;
            $display("FAIL %s done: done=%b err=%b req=%b be=%b busy=%b, want 1 0 0 0000 1",
                     tag, done, err, mem_req, mem_be, busy);
        end
        cyc();
        start = 1'b0;
        checks++;
        if (!(done === 1'b0 && busy === 1'b0 && mem_req === 1'b0)) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b req=%b, want 0 0 0",
                     tag, done, busy, mem_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        mem_ack = 1'b1;
        size = 2'd0;
        addr = 32'h1234;
        wdata = 32'hFFFF;
        cyc();
        cyc();
        checks++;
        if (!(mem_req === 1'b0 && mem_be === 4'd0 && mem_addr === 32'd0
              && mem_wdata === 32'd0 && busy === 1'b0 && done === 1'b0
              && err === 1'b0)) begin
            errors++;
            $display("FAIL reset: req=%b be=%b addr=%h data=%h busy=%b done=%b err=%b, want all zero",
                     mem_req, mem_be, mem_addr, mem_wdata, busy, done, err);
        end
        rst = 1'b0;
        start = 1'b0;
        mem_ack = 1'b0;
        cyc();
    endtask

    task automatic test_byte();
        run_txn(2'b00, 32'h1003, 32'hDEADBEEF, 2, 1'b0, "byte");
        checks++;
        if (mem_addr !== 32'h1000 || mem_wdata !== 32'hEFEFEFEF) begin
            errors++;
            $display("FAIL byte_latched: addr=%h data=%h, want 00001000 efefefef",
                     mem_addr, mem_wdata);
        end
    endtask

    task automatic test_half();
        run_txn(2'b01, 32'h2002, 32'h1234CAFE, 0, 1'b0, "half");
    endtask

    task automatic test_misaligned_word();
        run_txn(2'b10, 32'h3001, 32'h89ABCDEF, 1, 1'b0, "mis_word");
    endtask

    task automatic test_reserved();
        run_txn(2'b11, 32'h4000, 32'h55AA55AA, 0, 1'b0, "reserved");
    endtask

    task automatic test_back_to_back();
        run_txn(2'b00, 32'h5001, 32'h000000A5, 5, 1'b1, "spam");
        run_txn(2'b10, 32'h6000, 32'h0BADF00D, 0, 1'b0, "b2b");
    endtask

    task automatic test_reset_in_req();
        start = 1'b1;
        size = 2'b10;
        addr = 32'h7000;
        wdata = 32'h11223344;
        cyc();
        start = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_req_pre: req=%b, want 1", mem_req);
        end
        rst = 1'b1;
        mem_ack = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (!(mem_req === 1'b0 && mem_be === 4'd0 && busy === 1'b0
              && done === 1'b0 && mem_addr === 32'd0
              && mem_wdata === 32'd0)) begin
            errors++;
            $display("FAIL rst_req: req=%b be=%b busy=%b done=%b addr=%h data=%h, want 0 0 0 0 0 0",
                     mem_req, mem_be, busy, done, mem_addr, mem_wdata);
        end
        cyc();
        mem_ack = 1'b0;
        checks++;
        if (!(done === 1'b0 && busy === 1'b0 && mem_req === 1'b0)) begin
            errors++;
            $display("FAIL rst_late_ack: done=%b busy=%b req=%b, want 0 0 0",
                     done, busy, mem_req);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_txn(2'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                    "rand");
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        size = 2'd0;
        addr = 32'd0;
        wdata = 32'd0;
        mem_ack = 1'b0;
        test_reset();
        test_byte();
        test_half();
        test_misaligned_word();
        test_reserved();
        test_back_to_back();
        test_reset_in_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
